keypad_scanner: RTL
===================

# keypad_scanner

Scans the 4x3 safe keypad matrix, synchronises and debounces the row returns, and converts each clean key press into the strobes consumed by the password comparator. Digit keys produce a 4-bit 8421 BCD code on `data` plus one `is_pressed` pulse, and `*` produces one `is_star_pressed` pulse. The block sits directly upstream of the comparator and is its only source of keypad events.

## Interface
- `SCAN_DIV`, default 4: clock cycles per column slot; must be ≥3.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required for a key state to be accepted.
- `PULSE_CYCLES`, default 2: width of each output strobe, in cycles.

- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `row_n` in 4: keypad row returns, active-low, externally pulled up, asynchronous.
- `col_n` out 3: column drives, active-low, exactly one low at a time.
- `data` out 4: BCD code of the last accepted digit.
- `is_pressed` out 1: digit strobe.
- `is_star_pressed` out 1: `*` strobe.
- `is_hash_pressed` out 1: `#` strobe. Tied 0 unless `KEYPAD_HASH_EN` is defined.

## Operation
- Key map by row/column:
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Digits are encoded as BCD 0–9.
- `row_n` passes through a 2-flop synchroniser before any use.
- Scan:
  - A slot counter counts 0..SCAN_DIV-1.
  - The column index advances 0→1→2→0 when the slot counter wraps.
  - `col_n` drives the current column low.
  - Synchronised rows are sampled at slot count SCAN_DIV-1.
- Scan result is assembled over the 3 slots (one full scan = 3·SCAN_DIV cycles):
  - exactly one closed contact → that key id (0–11);
  - zero or ≥2 closed contacts → NONE.
- Debounce:
  - At the end of each scan, the result is compared with the previous scan's result.
  - If equal, a saturating match counter increments; otherwise it is set to 1.
  - When the counter reaches DEBOUNCE_SCANS, the result becomes `stable_key`.
- FSM states and transitions:
  - IDLE: if `stable_key` is a key → SETUP.
  - SETUP (1 cycle):
    - digit: load `data`;
    - `*` or `#`: `data` is unchanged.
    - Then → PULSE.
  - PULSE (PULSE_CYCLES cycles): assert the strobe matching the key class. Then → RELEASE.
  - RELEASE: wait until `stable_key` == NONE, then → IDLE.
- No auto-repeat: one strobe per press, however long the key is held.
- A key change without an intervening stable NONE (roll-over) is never emitted.
- `#` without `KEYPAD_HASH_EN`: SETUP/PULSE are skipped and the FSM goes straight to RELEASE; no strobe, `data` unchanged.
- At most one strobe is high in any cycle.

## Timing
- Reset values:
  - `col_n` = 3'b110
  - `data` = 4'h0
  - all strobes = 0
  - FSM = IDLE
  - slot counter, column, match counter, synchroniser = 0
  - `stable_key` = NONE, previous scan = NONE
- Press-to-strobe latency:
  - `stable_key` updates on the edge that ends the qualifying scan.
  - `data` is valid one edge later (SETUP).
  - The strobe rises one edge after that.
  - With defaults, a key closed before a scan begins yields the strobe at cycle 4·12 + 2 after that scan's start.
- `data` is stable ≥1 cycle before the strobe rises and through the strobe and its fall. It changes only in SETUP.
- The strobe falls after exactly PULSE_CYCLES high cycles.
- Assertion of `reset` at any point (mid-scan, SETUP, PULSE) immediately forces all reset values. A strobe in progress is cut, not completed.
- A key still held after reset release is re-debounced and emitted once.

## Configuration
- `KEYPAD_HASH_EN` defined: `#` is debounced like any key and yields an `is_hash_pressed` pulse of PULSE_CYCLES cycles; `data` is unchanged.
- `KEYPAD_HASH_EN` undefined: `is_hash_pressed` is constant 0 and `#` only occupies the RELEASE wait.

## Test plan
- Reset asserted mid-scan → `col_n`=110, `data`=0, all strobes 0 on the same cycle.
- Clean hold of r1/c1 ('5') for 6 scans → `data`=4'h5 one cycle before `is_pressed`; `is_pressed` high for exactly 2 cycles; no further pulse while held.
- Bounce on '7' (closed 2 scans, open 1 scan, closed 2 scans), then release → no strobe; `data` unchanged.
- '1' and '2' held simultaneously for 8 scans → no strobe.
- Press '*' after '9' → `is_star_pressed` 2-cycle pulse, `is_pressed` stays 0, `data` stays 4'h9.
- Hold '0' and assert reset during PULSE → strobe drops immediately. After release of reset, exactly one new `is_pressed` pulse with `data`=4'h0.
- `#` press:
  - with `KEYPAD_HASH_EN` → one 2-cycle `is_hash_pressed` pulse;
  - without it → all strobes stay 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x3 keypad, debounces whole-scan results and emits one
// strobe per clean press. Define KEYPAD_HASH_EN to give '#' its own is_hash_pressed strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int PULSE_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] data,
    output logic       is_pressed,
    output logic       is_star_pressed,
    output logic       is_hash_pressed
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PCNT_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SCANS);
    localparam logic [PCNT_W-1:0]  PCNT_LAST  = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_HASH = 4'd11;
`ifdef KEYPAD_HASH_EN
    localparam logic HASH_EN = 1'b1;
`else
    localparam logic HASH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PULSE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic logic [1:0] hit_count(input logic [3:0] closed);
        logic [1:0] n;
        case (closed)
            4'b0000:                            n = 2'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: n = 2'd1;
            default:                            n = 2'd2;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] hit_row(input logic [3:0] closed);
        logic [1:0] r;
        case (closed)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] key_to_bcd(input logic [3:0] key);
        logic [3:0] bcd;
        case (key)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: bcd = key + 4'd1;
            4'd10:   bcd = 4'd0;
            default: bcd = 4'd0;
        endcase
        return bcd;
    endfunction

    // Strobe bit order is {hash, star, digit}.
    function automatic logic [2:0] key_class(input logic [3:0] key);
        logic [2:0] cls;
        case (key)
            KEY_STAR: cls = 3'b010;
            KEY_HASH: cls = 3'b100;
            default:  cls = 3'b001;
        endcase
        return cls;
    endfunction

    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]         col_q, col_d;
    logic [2:0]         col_n_q, col_n_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic [3:0]         acc_key_q, acc_key_d;
    logic [3:0]         prev_q, prev_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [3:0]         stable_q, stable_d;
    state_t             state_q, state_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic [3:0]         data_q, data_d;
    logic [2:0]         cls_q, cls_d;
    logic [2:0]         strobe_q, strobe_d;

    logic       sample, scan_end;
    logic [1:0] slot_hits, base_cnt, tot_cnt;
    logic [3:0] key_id, base_key, new_key, scan_result;

    // Scan timing, per-slot contact accumulation and whole-scan debounce.
    always_comb begin
        sync1_d   = row_n;
        sync2_d   = sync1_q;
        sample    = (slot_q == SLOT_LAST);
        scan_end  = sample && (col_q == 2'd2);
        slot_hits = hit_count(~sync2_q);
        key_id    = ({2'b00, hit_row(~sync2_q)} * 4'd3) + {2'b00, col_q};
        base_cnt  = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_key  = (col_q == 2'd0) ? KEY_NONE : acc_key_q;

        if (base_cnt == 2'd0) begin
            tot_cnt = slot_hits;
        end else if (slot_hits == 2'd0) begin
            tot_cnt = base_cnt;
        end else begin
            tot_cnt = 2'd2;
        end
        new_key     = (slot_hits == 2'd1) ? key_id : base_key;
        scan_result = (tot_cnt == 2'd1) ? new_key : KEY_NONE;

        if (sample) begin
            slot_d    = {SLOT_W{1'b0}};
            col_d     = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            acc_cnt_d = tot_cnt;
            acc_key_d = new_key;
        end else begin
            slot_d    = slot_q + SLOT_W'(1);
            col_d     = col_q;
            acc_cnt_d = acc_cnt_q;
            acc_key_d = acc_key_q;
        end
        col_n_d = ~(3'b001 << col_d);

        prev_d   = prev_q;
        match_d  = match_q;
        stable_d = stable_q;
        if (scan_end) begin
            prev_d = scan_result;
            if (scan_result == prev_q) begin
                match_d = (match_q == MATCH_FULL) ? match_q : match_q + MATCH_W'(1);
            end else begin
                match_d = MATCH_W'(1);
            end
            if (match_d == MATCH_FULL) begin
                stable_d = scan_result;
            end else begin
                stable_d = stable_q;
            end
        end else begin
            prev_d = prev_q;
        end
    end

    // Press FSM: data is loaded on entry to SETUP so it leads the strobe by a cycle.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cls_d    = cls_q;
        pcnt_d   = pcnt_q;
        strobe_d = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (stable_q == KEY_NONE) begin
                    state_d = ST_IDLE;
                end else if ((stable_q == KEY_HASH) && !HASH_EN) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_SETUP;
                    cls_d   = key_class(stable_q);
                    if ((stable_q != KEY_STAR) && (stable_q != KEY_HASH)) begin
                        data_d = key_to_bcd(stable_q);
                    end else begin
                        data_d = data_q;
                    end
                end
            end
            ST_SETUP: begin
                state_d  = ST_PULSE;
                pcnt_d   = {PCNT_W{1'b0}};
                strobe_d = cls_q;
            end
            ST_PULSE: begin
                if (pcnt_q == PCNT_LAST) begin
                    state_d  = ST_RELEASE;
                    strobe_d = 3'b000;
                end else begin
                    pcnt_d   = pcnt_q + PCNT_W'(1);
                    strobe_d = strobe_q;
                end
            end
            ST_RELEASE: begin
                if (stable_q == KEY_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 4'h0;
            sync2_q   <= 4'h0;
            slot_q    <= {SLOT_W{1'b0}};
            col_q     <= 2'd0;
            col_n_q   <= 3'b110;
            acc_cnt_q <= 2'd0;
            acc_key_q <= KEY_NONE;
            prev_q    <= KEY_NONE;
            match_q   <= {MATCH_W{1'b0}};
            stable_q  <= KEY_NONE;
            state_q   <= ST_IDLE;
            pcnt_q    <= {PCNT_W{1'b0}};
            data_q    <= 4'h0;
            cls_q     <= 3'b000;
            strobe_q  <= 3'b000;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            slot_q    <= slot_d;
            col_q     <= col_d;
            col_n_q   <= col_n_d;
            acc_cnt_q <= acc_cnt_d;
            acc_key_q <= acc_key_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            stable_q  <= stable_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            data_q    <= data_d;
            cls_q     <= cls_d;
            strobe_q  <= strobe_d;
        end
    end

    assign col_n           = col_n_q;
    assign data            = data_q;
    assign is_pressed      = strobe_q[0];
    assign is_star_pressed = strobe_q[1];
`ifdef KEYPAD_HASH_EN
    assign is_hash_pressed = strobe_q[2];
`else
    assign is_hash_pressed = 1'b0;
`endif

endmodule
